// File: rtl/y86_seq_controller.sv
// Multi-cycle sequencer for the Y86-64 SEQ datapath: walks each instruction through
// its six stages, waits on the memory handshakes and reports the Y86 status code.
module y86_seq_controller #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             imem_ready,
   input  logic             imem_error,
   input  logic [3:0]       icode,
   input  logic             dmem_ready,
   input  logic             dmem_error,
   output logic             fetch_en,
   output logic             decode_en,
   output logic             execute_en,
   output logic             mem_en,
   output logic             wb_en,
   output logic             pc_en,
   output logic             dmem_req,
   output logic             halted,
   output logic [2:0]       stat,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_PCUPD, S_HALT
   } state_t;

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;
   localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

   state_t     state;
   logic [3:0] icode_q;
   logic [7:0] tmo_cnt;

   function automatic logic is_mem_icode(input logic [3:0] ic);
      case (ic)
         4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: is_mem_icode = 1'b1;
         default:                            is_mem_icode = 1'b0;
      endcase
   endfunction

   // Enables are a pure decode of the registered state, so they hold for the whole cycle.
   assign fetch_en   = (state == S_FETCH);
   assign decode_en  = (state == S_DECODE);
   assign execute_en = (state == S_EXECUTE);
   assign mem_en     = (state == S_MEMORY);
   assign wb_en      = (state == S_WRITEBACK);
   assign pc_en      = (state == S_PCUPD);
   assign dmem_req   = (state == S_MEMORY) && is_mem_icode(icode_q);
   assign halted     = (state == S_HALT);

   // NOTE: every register here is updated with <= so all of them see the same pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         stat        <= STAT_AOK;
         cycle_count <= '0;
         instr_count <= '0;
         icode_q     <= 4'h0;
         tmo_cnt     <= 8'd0;
      end else begin
         if (state != S_HALT)
            cycle_count <= cycle_count + CNT_W'(1);

         case (state)
            S_IDLE: state <= S_FETCH;
            S_FETCH: begin
               if (imem_ready) begin
                  if (imem_error) begin
                     stat  <= STAT_ADR;
                     state <= S_HALT;
                  end else if (icode > 4'hB) begin
                     stat  <= STAT_INS;
                     state <= S_HALT;
                  end else if (icode == 4'h0) begin
                     stat  <= STAT_HLT;
                     state <= S_HALT;
                  end else begin
                     icode_q <= icode;
                     state   <= S_DECODE;
                  end
               end
            end
            S_DECODE: state <= S_EXECUTE;
            S_EXECUTE: begin
               tmo_cnt <= 8'd0;
               state   <= S_MEMORY;
            end
            S_MEMORY: begin
               // A ready that lands on the final allowed cycle still wins over the timeout.
               if (!is_mem_icode(icode_q)) begin
                  state <= S_WRITEBACK;
               end else if (dmem_ready) begin
                  if (dmem_error) begin
                     stat  <= STAT_ADR;
                     state <= S_HALT;
                  end else begin
                     state <= S_WRITEBACK;
                  end
               end else if (tmo_cnt == TMO_LAST) begin
                  stat  <= STAT_ADR;
                  state <= S_HALT;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            S_WRITEBACK: state <= S_PCUPD;
            S_PCUPD: begin
               instr_count <= instr_count + CNT_W'(1);
               state       <= S_FETCH;
            end
            S_HALT:  state <= S_HALT;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
